// File: rtl/rtc_time_ctrl.sv
// DS1302 time sequencer: runs optional power-up init writes, polls 3..7 time
// registers in bursts, services set-time requests between bursts, and guards
// every engine transaction with a timeout that raises a sticky error flag.
module rtc_time_ctrl #(
  parameter int          NUM_REGS    = 3,
  parameter int          INIT_EN     = 1,
  parameter logic [7:0]  INIT_HOUR   = 8'h12,
  parameter logic [7:0]  INIT_MIN    = 8'h22,
  parameter logic [7:0]  INIT_SEC    = 8'h22,
  parameter logic [23:0] POLL_DIV    = 24'd500000,
  parameter logic [15:0] TIMEOUT_CYC = 16'd4000
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       Set_Req,
  input  logic [7:0] Set_Hour,
  input  logic [7:0] Set_Min,
  input  logic [7:0] Set_Sec,
  output logic       Set_Busy,
  output logic       Cmd_Start,
  output logic [7:0] Cmd_Byte,
  output logic [7:0] Cmd_Wdata,
  input  logic       Cmd_Done,
  input  logic [7:0] Cmd_Rdata,
  output logic [7:0] Time_second,
  output logic [7:0] Time_munite,
  output logic [7:0] Time_hour,
  output logic [7:0] Time_date,
  output logic [7:0] Time_month,
  output logic [7:0] Time_day,
  output logic [7:0] Time_year,
  output logic       Time_Valid,
  output logic       Err
);

  typedef enum logic [3:0] {
    S_INIT_WP, S_INIT_H, S_INIT_M, S_INIT_S,
    S_READ, S_WAIT,
    S_SET_WP, S_SET_H, S_SET_M, S_SET_S
  } state_t;

  localparam state_t     RST_STATE = (INIT_EN != 0) ? S_INIT_WP : S_READ;
  localparam logic [2:0] LAST_IDX  = 3'(NUM_REGS - 1);
  localparam logic [7:0] WP_CMD    = 8'h8E;

  // Write command for register r; read command sets bit0.
  function automatic logic [7:0] wr_cmd(input logic [2:0] r);
    return 8'h80 + {4'b0000, r, 1'b0};
  endfunction

  function automatic logic [7:0] rd_cmd(input logic [2:0] r);
    return wr_cmd(r) | 8'h01;
  endfunction

  // Clear the clock-halt bit of a seconds value.
  function automatic logic [7:0] clr_ch(input logic [7:0] v);
    return {1'b0, v[6:0]};
  endfunction

  state_t      state, state_n;
  logic [2:0]  idx, idx_n;
  logic        cmd_start_n;
  logic [7:0]  cmd_byte_n, cmd_wdata_n;
  logic [23:0] wait_cnt, wait_n;
  logic        set_busy_n;
  logic        set_pend, set_pend_n;
  logic        err_n;
  logic        time_valid_n;
  logic        accept;
  logic [15:0] tmo_cnt;
  logic        tmo_hit;
  logic        step_done;
  logic [7:0]  issue_byte, issue_wdata;
  logic [7:0]  set_h, set_m, set_s;

  assign tmo_hit   = Cmd_Start && (tmo_cnt == (TIMEOUT_CYC - 16'd1));
  assign step_done = Cmd_Start && (Cmd_Done || tmo_hit);

  // Command byte and write data belonging to the current sequence step.
  always_comb begin
    issue_byte  = 8'h00;
    issue_wdata = 8'h00;
    case (state)
      S_INIT_WP, S_SET_WP: begin issue_byte = WP_CMD;       issue_wdata = 8'h00;            end
      S_INIT_H:            begin issue_byte = wr_cmd(3'd2); issue_wdata = INIT_HOUR;        end
      S_INIT_M:            begin issue_byte = wr_cmd(3'd1); issue_wdata = INIT_MIN;         end
      S_INIT_S:            begin issue_byte = wr_cmd(3'd0); issue_wdata = clr_ch(INIT_SEC); end
      S_SET_H:             begin issue_byte = wr_cmd(3'd2); issue_wdata = set_h;            end
      S_SET_M:             begin issue_byte = wr_cmd(3'd1); issue_wdata = set_m;            end
      S_SET_S:             begin issue_byte = wr_cmd(3'd0); issue_wdata = set_s;            end
      S_READ:              begin issue_byte = rd_cmd(idx);  issue_wdata = 8'h00;            end
      default: ;
    endcase
  end

  // Next-state logic: issue a transaction when idle in a command state,
  // advance on completion or timeout, and arbitrate set requests in WAIT.
  always_comb begin
    state_n      = state;
    idx_n        = idx;
    cmd_start_n  = Cmd_Start;
    cmd_byte_n   = Cmd_Byte;
    cmd_wdata_n  = Cmd_Wdata;
    wait_n       = wait_cnt;
    set_busy_n   = Set_Busy;
    set_pend_n   = set_pend;
    time_valid_n = 1'b0;
    accept       = 1'b0;
    err_n        = Err | (tmo_hit & ~Cmd_Done);

    if (state == S_WAIT) begin
      if (set_pend || Set_Req) begin
        accept     = 1'b1;
        state_n    = S_SET_WP;
        set_busy_n = 1'b1;
      end else if (wait_cnt == POLL_DIV) begin
        state_n = S_READ;
        idx_n   = 3'd0;
      end else begin
        wait_n = wait_cnt + 24'd1;
      end
    end else if (!Cmd_Start) begin
      cmd_start_n = 1'b1;
      cmd_byte_n  = issue_byte;
      cmd_wdata_n = issue_wdata;
    end else if (step_done) begin
      cmd_start_n = 1'b0;
      case (state)
        S_INIT_WP: state_n = S_INIT_H;
        S_INIT_H:  state_n = S_INIT_M;
        S_INIT_M:  state_n = S_INIT_S;
        S_INIT_S:  begin state_n = S_READ; idx_n = 3'd0; end
        S_SET_WP:  state_n = S_SET_H;
        S_SET_H:   state_n = S_SET_M;
        S_SET_M:   state_n = S_SET_S;
        S_SET_S:   begin state_n = S_READ; idx_n = 3'd0; set_busy_n = 1'b0; end
        S_READ: begin
          if (idx == LAST_IDX) begin
            state_n      = S_WAIT;
            idx_n        = 3'd0;
            wait_n       = 24'd0;
            time_valid_n = 1'b1;
          end else begin
            idx_n = idx + 3'd1;
          end
        end
        default: ;
      endcase
    end

    if (accept)       set_pend_n = 1'b0;
    else if (Set_Req) set_pend_n = 1'b1;
  end

  // Sequencer state and registered command interface.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state      <= RST_STATE;
      idx        <= 3'd0;
      Cmd_Start  <= 1'b0;
      Cmd_Byte   <= 8'h00;
      Cmd_Wdata  <= 8'h00;
      wait_cnt   <= 24'd0;
      Set_Busy   <= 1'b0;
      set_pend   <= 1'b0;
      Err        <= 1'b0;
      Time_Valid <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      Cmd_Start  <= cmd_start_n;
      Cmd_Byte   <= cmd_byte_n;
      Cmd_Wdata  <= cmd_wdata_n;
      wait_cnt   <= wait_n;
      Set_Busy   <= set_busy_n;
      set_pend   <= set_pend_n;
      Err        <= err_n;
      Time_Valid <= time_valid_n;
    end
  end

  // Transaction timeout counter; runs only while a request is outstanding.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)                       tmo_cnt <= 16'd0;
    else if (Cmd_Start && !step_done) tmo_cnt <= tmo_cnt + 16'd1;
    else                             tmo_cnt <= 16'd0;
  end

  // Set-time values captured at acceptance, not at request time.
  always_ff @(posedge CLK) begin
    if (accept) begin
      set_h <= Set_Hour;
      set_m <= Set_Min;
      set_s <= clr_ch(Set_Sec);
    end
  end

  // Latch read data into the time register addressed by the current read.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      Time_second <= 8'h00;
      Time_munite <= 8'h00;
      Time_hour   <= 8'h00;
      Time_date   <= 8'h00;
      Time_month  <= 8'h00;
      Time_day    <= 8'h00;
      Time_year   <= 8'h00;
    end else if (state == S_READ && Cmd_Start && Cmd_Done) begin
      case (idx)
        3'd0: Time_second <= clr_ch(Cmd_Rdata);
        3'd1: Time_munite <= Cmd_Rdata;
        3'd2: Time_hour   <= Cmd_Rdata;
        3'd3: Time_date   <= Cmd_Rdata;
        3'd4: Time_month  <= Cmd_Rdata;
        3'd5: Time_day    <= Cmd_Rdata;
        3'd6: Time_year   <= Cmd_Rdata;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_time_ctrl.sv
// Directed bench for rtc_time_ctrl with a behavioural DS1302 engine model.
module tb_rtc_time_ctrl;
  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       Set_Req = 1'b0;
  logic [7:0] Set_Hour = 8'h00, Set_Min = 8'h00, Set_Sec = 8'h00;
  logic       Set_Busy, Cmd_Start;
  logic [7:0] Cmd_Byte, Cmd_Wdata;
  logic       Cmd_Done = 1'b0;
  logic [7:0] Cmd_Rdata = 8'h00;
  logic [7:0] Time_second, Time_munite, Time_hour, Time_date, Time_month, Time_day, Time_year;
  logic       Time_Valid, Err;

  int checks = 0;
  int errors = 0;

  rtc_time_ctrl #(
    .NUM_REGS(7), .INIT_EN(1), .INIT_HOUR(8'h12), .INIT_MIN(8'h22), .INIT_SEC(8'h22),
    .POLL_DIV(24'd100), .TIMEOUT_CYC(16'd50)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .Set_Req(Set_Req), .Set_Hour(Set_Hour), .Set_Min(Set_Min),
    .Set_Sec(Set_Sec), .Set_Busy(Set_Busy), .Cmd_Start(Cmd_Start), .Cmd_Byte(Cmd_Byte),
    .Cmd_Wdata(Cmd_Wdata), .Cmd_Done(Cmd_Done), .Cmd_Rdata(Cmd_Rdata),
    .Time_second(Time_second), .Time_munite(Time_munite), .Time_hour(Time_hour),
    .Time_date(Time_date), .Time_month(Time_month), .Time_day(Time_day),
    .Time_year(Time_year), .Time_Valid(Time_Valid), .Err(Err)
  );

  always #5 CLK = ~CLK;

  // Engine model: Done ten cycles after Start, except a hung read of 83.
  int eng_cnt = 0;
  bit hang = 1'b0;

  function automatic logic [7:0] reg_val(input logic [7:0] b);
    case (b)
      8'h81: return 8'hD9;
      8'h83: return 8'h59;
      8'h85: return 8'h23;
      8'h87: return 8'h31;
      8'h89: return 8'h12;
      8'h8B: return 8'h07;
      8'h8D: return 8'h99;
      default: return 8'h00;
    endcase
  endfunction

  always @(negedge CLK) begin
    Cmd_Done = 1'b0;
    if (RSTn && Cmd_Start) begin
      eng_cnt = eng_cnt + 1;
      if (hang && Cmd_Byte == 8'h83) Cmd_Rdata = 8'hAA;
      else if (eng_cnt == 10) begin
        Cmd_Done  = 1'b1;
        Cmd_Rdata = reg_val(Cmd_Byte);
      end
    end else begin
      eng_cnt = 0;
    end
  end

  // Transaction log: command, data, Set_Busy at issue, and edge cycles.
  int         cyc = 0;
  bit         prev_start = 1'b0;
  logic [7:0] held_byte = 8'h00;
  int         unstable = 0;
  logic [7:0] log_byte[$];
  logic [7:0] log_wd[$];
  logic       log_busy[$];
  int         log_cyc[$];
  int         fall_cyc[$];
  int         valid_cyc[$];

  always @(negedge CLK) begin
    cyc = cyc + 1;
    if (Cmd_Start && !prev_start) begin
      log_byte.push_back(Cmd_Byte);
      log_wd.push_back(Cmd_Wdata);
      log_busy.push_back(Set_Busy);
      log_cyc.push_back(cyc);
      held_byte = Cmd_Byte;
    end else if (Cmd_Start && Cmd_Byte != held_byte) begin
      unstable = unstable + 1;
    end
    if (!Cmd_Start && prev_start) fall_cyc.push_back(cyc);
    prev_start = Cmd_Start;
    if (Time_Valid) valid_cyc.push_back(cyc);
  end

  function automatic logic [7:0] lb(input int i);
    if (i >= 0 && i < log_byte.size()) return log_byte[i];
    return 8'h00;
  endfunction
  function automatic logic [7:0] lw(input int i);
    if (i >= 0 && i < log_wd.size()) return log_wd[i];
    return 8'h00;
  endfunction
  function automatic logic lbusy(input int i);
    if (i >= 0 && i < log_busy.size()) return log_busy[i];
    return 1'bx;
  endfunction
  function automatic int lc(input int i);
    if (i >= 0 && i < log_cyc.size()) return log_cyc[i];
    return 32'h7fffffff;
  endfunction
  function automatic int fc(input int i);
    if (i >= 0 && i < fall_cyc.size()) return fall_cyc[i];
    return 0;
  endfunction
  function automatic int vc(input int i);
    if (i >= 0 && i < valid_cyc.size()) return valid_cyc[i];
    return 0;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask
  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask
  task automatic chk32(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_log(input int n, input string tag);
    int k = 0;
    while (log_byte.size() < n && k < 3000) begin @(negedge CLK); k++; end
    chk1(tag, log_byte.size() >= n, 1'b1);
  endtask
  task automatic wait_valid(input int n, input string tag);
    int k = 0;
    while (valid_cyc.size() < n && k < 3000) begin @(negedge CLK); k++; end
    chk1(tag, valid_cyc.size() >= n, 1'b1);
  endtask
  task automatic wait_fall(input int n, input string tag);
    int k = 0;
    while (fall_cyc.size() < n && k < 3000) begin @(negedge CLK); k++; end
    chk1(tag, fall_cyc.size() >= n, 1'b1);
  endtask

  logic [7:0] exp_init [11];
  logic [7:0] exp_iwd  [4];
  logic [7:0] exp_time [7];
  logic [7:0] exp_set  [9];
  logic [7:0] exp_swd  [9];
  logic       exp_sbusy[9];

  initial begin
    int k, n0, n1, n2, nv, g0, gap, j;
    exp_init  = '{8'h8E, 8'h84, 8'h82, 8'h80, 8'h81, 8'h83, 8'h85, 8'h87, 8'h89, 8'h8B, 8'h8D};
    exp_iwd   = '{8'h00, 8'h12, 8'h22, 8'h22};
    exp_time  = '{8'h59, 8'h59, 8'h23, 8'h31, 8'h12, 8'h07, 8'h99};
    exp_set   = '{8'h87, 8'h89, 8'h8B, 8'h8D, 8'h8E, 8'h84, 8'h82, 8'h80, 8'h81};
    exp_swd   = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08, 8'h30, 8'h45, 8'h00};
    exp_sbusy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(negedge CLK);
    chk1("rst_start", Cmd_Start, 1'b0);
    chk8("rst_byte", Cmd_Byte, 8'h00);
    chk8("rst_wdata", Cmd_Wdata, 8'h00);
    chk1("rst_busy", Set_Busy, 1'b0);
    chk1("rst_valid", Time_Valid, 1'b0);
    chk1("rst_err", Err, 1'b0);
    chk8("rst_sec", Time_second, 8'h00);
    chk8("rst_year", Time_year, 8'h00);
    RSTn = 1'b1;

    // Init writes followed by the first read burst
    wait_log(11, "init_log_wait");
    for (int i = 0; i < 11; i++) chk8($sformatf("init_cmd%0d", i), lb(i), exp_init[i]);
    for (int i = 0; i < 4; i++)  chk8($sformatf("init_wd%0d", i), lw(i), exp_iwd[i]);

    wait_valid(1, "first_valid_wait");
    chk8("t_sec", Time_second, exp_time[0]);
    chk8("t_min", Time_munite, exp_time[1]);
    chk8("t_hour", Time_hour, exp_time[2]);
    chk8("t_date", Time_date, exp_time[3]);
    chk8("t_month", Time_month, exp_time[4]);
    chk8("t_day", Time_day, exp_time[5]);
    chk8("t_year", Time_year, exp_time[6]);

    // Poll gap and one Time_Valid per burst over five bursts
    wait_valid(6, "burst_wait");
    g0 = 0;
    for (int i = 0; i < 5; i++) begin
      j = -1;
      for (int m = 0; m < log_cyc.size(); m++)
        if (j < 0 && log_cyc[m] > vc(i)) j = m;
      gap = lc(j) - vc(i);
      chk1($sformatf("gap_range%0d(%0d)", i, gap), gap >= 100 && gap <= 102, 1'b1);
      if (i == 0) g0 = gap;
      else chk32($sformatf("gap_const%0d", i), gap, g0);
      chk8($sformatf("burst_first%0d", i), lb(j), 8'h81);
      chk8($sformatf("burst_last%0d", i), lb(j + 6), 8'h8D);
      chk1($sformatf("one_valid%0d", i), lc(j + 6) < vc(i + 1) && lc(j + 7) > vc(i + 1), 1'b1);
    end

    // Set request raised mid-burst
    k = 0;
    while (!(Cmd_Start && Cmd_Byte == 8'h85) && k < 3000) begin @(negedge CLK); k++; end
    chk1("set_find85", Cmd_Start && Cmd_Byte == 8'h85, 1'b1);
    @(negedge CLK);
    n0 = log_byte.size() - 1;
    chk8("set_at85", lb(n0), 8'h85);
    Set_Hour = 8'h11; Set_Min = 8'h30; Set_Sec = 8'hC5; Set_Req = 1'b1;
    @(negedge CLK);
    Set_Req = 1'b0; Set_Hour = 8'h08;
    @(negedge CLK);
    chk1("set_busy_during_burst", Set_Busy, 1'b0);
    wait_log(n0 + 10, "set_log_wait");
    for (int i = 0; i < 9; i++) begin
      chk8($sformatf("set_cmd%0d", i), lb(n0 + 1 + i), exp_set[i]);
      chk8($sformatf("set_wd%0d", i), lw(n0 + 1 + i), exp_swd[i]);
      chk1($sformatf("set_busy%0d", i), lbusy(n0 + 1 + i), exp_sbusy[i]);
    end
    chk1("set_busy_after", Set_Busy, 1'b0);

    // Read of 83 never completes
    hang = 1'b1;
    n1 = n0 + 10;
    wait_log(n1 + 1, "tmo_log_wait");
    chk8("tmo_cmd", lb(n1), 8'h83);
    wait_fall(n1 + 1, "tmo_fall_wait");
    chk32("tmo_duration", fc(n1) - lc(n1), 50);
    chk1("tmo_err", Err, 1'b1);
    wait_log(n1 + 2, "tmo_next_wait");
    chk8("tmo_next_cmd", lb(n1 + 1), 8'h85);
    nv = valid_cyc.size();
    wait_valid(nv + 1, "tmo_valid_wait");
    chk8("tmo_min_kept", Time_munite, 8'h59);
    chk8("tmo_hour", Time_hour, 8'h23);
    chk1("tmo_err_sticky", Err, 1'b1);
    hang = 1'b0;
    nv = valid_cyc.size();
    wait_valid(nv + 1, "post_tmo_valid_wait");
    chk1("err_still_set", Err, 1'b1);

    // Reset asserted during a transaction
    k = 0;
    while (!Cmd_Start && k < 3000) begin @(negedge CLK); k++; end
    chk1("rst_mid_find", Cmd_Start, 1'b1);
    #2 RSTn = 1'b0;
    #1;
    chk1("rst_mid_start", Cmd_Start, 1'b0);
    chk1("rst_mid_err", Err, 1'b0);
    chk8("rst_mid_sec", Time_second, 8'h00);
    chk8("rst_mid_min", Time_munite, 8'h00);
    chk8("rst_mid_byte", Cmd_Byte, 8'h00);
    chk1("rst_mid_busy", Set_Busy, 1'b0);
    chk1("rst_mid_valid", Time_Valid, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    RSTn = 1'b1;
    n2 = log_byte.size();
    wait_log(n2 + 1, "restart_wait");
    chk8("restart_cmd", lb(n2), 8'h8E);
    chk8("restart_wd", lw(n2), 8'h00);
    chk1("restart_err", Err, 1'b0);

    chk32("byte_stable", unstable, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rtc_time_ctrl.md
Name: rtc_time_ctrl

Overview:
- Parametrised DS1302 time sequencer; successor of the fixed 3-register set/read loop.
- Sits between user logic and the byte-level DS1302 transaction engine, which owns RST/SCLK/SIO.
- Optional power-up initialisation, runtime set-time requests, 3 to 7 polled time registers, programmable poll interval, per-transaction timeout with a sticky error flag.

Parameters:
- NUM_REGS, 3: time registers polled per burst; legal 3..7, in order sec, min, hour, date, month, day, year.
- INIT_EN, 1: 1 = write WP-off, hour, min, sec after reset; 0 = start polling immediately.
- INIT_HOUR, 8'h12: BCD hour written during init.
- INIT_MIN, 8'h22: BCD minute written during init.
- INIT_SEC, 8'h22: BCD second written during init; bit7 (CH) forced 0.
- POLL_DIV, 24'd500000: idle CLK cycles between the end of one read burst and the start of the next; 0 = back-to-back.
- TIMEOUT_CYC, 16'd4000: max CLK cycles Cmd_Start may stay high without Cmd_Done.

Ports:
- CLK  in  1  system clock.
- RSTn  in  1  asynchronous active-low reset.
- Set_Req  in  1  pulse/level request to write Set_Hour/Set_Min/Set_Sec.
- Set_Hour  in  8  BCD hour; sampled when Set_Req is accepted.
- Set_Min  in  8  BCD minute; sampled when Set_Req is accepted.
- Set_Sec  in  8  BCD second; sampled when Set_Req is accepted.
- Set_Busy  out  1  high from acceptance to completion of a set sequence.
- Cmd_Start  out  1  transaction request to the engine.
- Cmd_Byte  out  8  DS1302 command byte.
- Cmd_Wdata  out  8  write data.
- Cmd_Done  in  1  one-cycle completion pulse from the engine.
- Cmd_Rdata  in  8  read data; valid while Cmd_Done is high.
- Time_second, Time_munite, Time_hour, Time_date, Time_month, Time_day, Time_year  out  8 each  latched BCD values.
- Time_Valid  out  1  one-cycle pulse after a complete read burst.
- Err  out  1  sticky timeout flag.

Behaviour:
Reset:
- All outputs 0; state = INIT_WP if INIT_EN, else READ with index 0.

Command encoding:
- Write address = 8'h80 + 2*reg; read = write | 1.
- Register numbers: sec 0, min 1, hour 2, date 3, month 4, day 5, year 6.
- WP register = 8'h8E, written with 8'h00.

Handshake:
- Cmd_Start, Cmd_Byte and Cmd_Wdata are registered and held stable while Cmd_Start = 1.
- In the cycle Cmd_Done = 1, the block registers read data and advances state; Cmd_Start is 0 on the next cycle.
- There is at least one cycle with Cmd_Start low between transactions.
- Cmd_Done while Cmd_Start = 0 is ignored.

States:
- INIT_WP -> INIT_H -> INIT_M -> INIT_S -> READ: init writes, hour first, seconds last, so the oscillator starts with CH = 0.
- READ(idx): idx counts 0..NUM_REGS-1 and issues the read of register idx. On Done, Cmd_Rdata goes to the matching Time_* register; seconds bit7 is masked to 0.
  - After idx = NUM_REGS-1: pulse Time_Valid in the same cycle as that register update, then go to WAIT.
  - Unpolled Time_* registers remain 0.
- WAIT: count POLL_DIV cycles, then go to READ(0). A pending set request is taken first.
- SET_WP -> SET_H -> SET_M -> SET_S -> READ(0): set sequence. Set_Busy drops in the cycle SET_S completes.

Set requests:
- A request is accepted only in WAIT, or at a READ burst boundary.
- Set_Req seen during a burst or during init is latched as pending (one deep); a repeat while pending is merged. Set_* values are sampled at acceptance, not at request time.
- Set_Req during SET_* is latched pending and serviced after the following read burst.
- Set_Sec bit7 is forced to 0.

Timeout:
- A counter runs while Cmd_Start = 1.
- On reaching TIMEOUT_CYC: drop Cmd_Start, set Err, treat the step as done with no data update, and advance.
- If the timeout hits the last read, Time_Valid is still pulsed.
- Err clears only on reset.

Reset mid-transaction: Cmd_Start drops asynchronously and the sequence restarts from the reset state.

Test Plan:
- INIT_EN = 1, engine model returning Done after 10 cycles: commands observed are 8E/00, 84/12, 82/22, 80/22, then 81, 83, 85 in order.
- NUM_REGS = 7, model returns sec = 8'hD9, min 8'h59, hour 8'h23, date 8'h31, month 8'h12, day 8'h07, year 8'h99: Time_second = 8'h59 (CH masked), others match; exactly one Time_Valid pulse per burst; 8D is the last read.
- POLL_DIV = 100: the gap from Time_Valid to the next Cmd_Start = 81 is 100 to 102 cycles, constant across 5 bursts.
- Set_Req with 08:30:45 asserted mid-burst: the burst finishes, then 8E/00, 84/08, 82/30, 80/45; Set_Busy spans exactly that sequence; the next burst starts at 81.
- Model never asserts Done on 83, TIMEOUT_CYC = 50: Cmd_Start drops after 50 cycles, Err = 1 and stays 1, Time_munite is unchanged, and polling continues with 85.
- RSTn pulsed low while Cmd_Start = 1: all outputs 0 immediately, and the init sequence restarts at 8E after release.
